// File: rtl/transfer_collector_if.sv
// Signal bundle between transfer_collector and its environment (two scanners plus the host port).
// The slave modport is the collector's view; the master modport is the scanners'/host's view.
interface transfer_collector_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_transfer;
    logic                  scan_1_ready_to_transfer;
    logic                  scan_2_ready_to_transfer;
    logic [DATA_WIDTH-1:0] scan_1_data;
    logic [DATA_WIDTH-1:0] scan_2_data;
    logic                  scan_1_valid;
    logic                  scan_2_valid;
    logic                  scan_1_transfer;
    logic                  scan_2_transfer;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  xfer_done;
    logic                  last_source;
    logic [3:0]            word_count;
    logic                  overflow;
    logic                  timeout;

    modport master (
        output start_transfer,
        output scan_1_ready_to_transfer, scan_2_ready_to_transfer,
        output scan_1_data, scan_2_data,
        output scan_1_valid, scan_2_valid,
        output out_ready,
        input  scan_1_transfer, scan_2_transfer,
        input  out_data, out_valid,
        input  busy, xfer_done, last_source, word_count, overflow, timeout
    );

    modport slave (
        input  start_transfer,
        input  scan_1_ready_to_transfer, scan_2_ready_to_transfer,
        input  scan_1_data, scan_2_data,
        input  scan_1_valid, scan_2_valid,
        input  out_ready,
        output scan_1_transfer, scan_2_transfer,
        output out_data, out_valid,
        output busy, xfer_done, last_source, word_count, overflow, timeout
    );
endinterface

// File: rtl/transfer_collector.sv
// Grants one of two scanners a transfer, buffers its words in a local FIFO and hands them to the host.
// Optional receive watchdog is built only when TRANSFER_TIMEOUT_EN is defined.
module transfer_collector #(
    parameter int DATA_WIDTH     = 8,
    parameter int WORDS_PER_XFER = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    transfer_collector_if.slave bus_io
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_WORD  = 4'(WORDS_PER_XFER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RECEIVE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  last_source_q, last_source_d;
    logic [3:0]            word_count_q, word_count_d;
    logic                  overflow_q, overflow_d;

    logic [1:0]            ready_v;
    logic [1:0]            valid_v;
    logic [1:0]            grant_v;
    logic [DATA_WIDTH-1:0] data_v [2];
    logic                  sel_ready;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  granting;
    logic                  push_req;
    logic                  idle_expired;

    // ------------------------------------------------------------------
    // Source selection: last_source_q doubles as the current grant owner
    // ------------------------------------------------------------------
    assign ready_v   = {bus_io.scan_2_ready_to_transfer, bus_io.scan_1_ready_to_transfer};
    assign valid_v   = {bus_io.scan_2_valid, bus_io.scan_1_valid};
    assign data_v[0] = bus_io.scan_1_data;
    assign data_v[1] = bus_io.scan_2_data;

    assign sel_ready = ready_v[last_source_q];
    assign sel_valid = valid_v[last_source_q];
    assign sel_data  = data_v[last_source_q];
    assign granting  = (state_q == S_GRANT) || (state_q == S_RECEIVE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_v[gi] = granting && (last_source_q == 1'(gi));
        end
    endgenerate

    assign bus_io.scan_1_transfer = grant_v[0];
    assign bus_io.scan_2_transfer = grant_v[1];

    // ------------------------------------------------------------------
    // Optional receive watchdog
    // ------------------------------------------------------------------
`ifdef TRANSFER_TIMEOUT_EN
    localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_q, timeout_d;

    // The counter only runs while waiting for the granted scanner's next word.
    assign idle_expired = (state_q == S_RECEIVE) && !sel_valid && (idle_cnt_q == IDLE_LIMIT);
    assign idle_cnt_d   = ((state_q != S_RECEIVE) || sel_valid) ? '0 : idle_cnt_q + 1'b1;
    assign timeout_d    = timeout_q | idle_expired;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_io.timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign idle_expired       = 1'b0;
    assign bus_io.timeout     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_source_d = last_source_q;
        word_count_d  = word_count_q;
        push_req      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus_io.start_transfer && (ready_v != 2'b00)) begin
                    // Round-robin only matters when both scanners compete.
                    last_source_d = (ready_v == 2'b11) ? ~last_source_q : ready_v[1];
                    word_count_d  = '0;
                    state_d       = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_RECEIVE;
            end
            S_RECEIVE: begin
                if (sel_valid && (word_count_q != LAST_WORD)) begin
                    push_req     = 1'b1;
                    word_count_d = word_count_q + 4'd1;
                end
                if ((word_count_q == LAST_WORD) || !sel_ready || idle_expired) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            last_source_q <= 1'b1;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_source_q <= last_source_d;
            word_count_q  <= word_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus_io.busy        = (state_q != S_IDLE);
    assign bus_io.xfer_done   = (state_q == S_DONE);
    assign bus_io.last_source = last_source_q;
    assign bus_io.word_count  = word_count_q;
    assign bus_io.overflow    = overflow_q;

    // ------------------------------------------------------------------
    // Local FIFO with a registered head word
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign fifo_full  = (count_q == FULL_COUNT);
    assign pop        = (count_q != '0) && bus_io.out_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign overflow_d = overflow_q | drop;

    // The head register reads the entry the read pointer will point at next.
    // If that entry is being written this cycle, the FIFO was draining to empty, so bypass.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        head_d   = mem_q[rd_ptr_d];
        if (count_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = sel_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign bus_io.out_data  = head_q;
    assign bus_io.out_valid = (count_q != '0);
endmodule
